// File: rtl/fiapp_fault_monitor.sv
// fiapp_fault_monitor: checks the fiapp stage invariants o3 == !o2 and
// o2 == previous o1 every armed cycle. It counts violating cycles, records
// which invariant failed and the cycle of the first failure, and raises an
// alarm with an irq/ack handshake once THRESH violations have been seen.
module fiapp_fault_monitor #(
    parameter int unsigned WARMUP = 2,
    parameter int unsigned THRESH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned CYC_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             obs_o1,
    input  logic             obs_o2,
    input  logic             obs_o3,
    input  logic             clr,
    input  logic             irq_ack,
    output logic             armed,
    output logic             alarm,
    output logic             irq,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       err_code,
    output logic             first_valid,
    output logic [CYC_W-1:0] first_stamp
);

    localparam int unsigned       WRM_W     = 4;
    localparam logic [WRM_W-1:0]  WARM_LAST = WRM_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  THRESH_V  = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ALARM   = 2'd2,
        ST_LATCHED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WRM_W-1:0] warm_q, warm_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             o1_prev_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       code_d;
    logic             fv_d;
    logic [CYC_W-1:0] fs_d;
    logic             checking;
    logic             v_cmp;
    logic             v_shf;
    logic             viol;

    // State and datapath registers; outputs are registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WARMUP;
            warm_q      <= '0;
            cyc_q       <= '0;
            o1_prev_q   <= 1'b0;
            err_cnt     <= '0;
            err_code    <= 2'b00;
            first_valid <= 1'b0;
            first_stamp <= '0;
            armed       <= 1'b0;
            alarm       <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            cyc_q       <= cyc_d;
            o1_prev_q   <= obs_o1;
            err_cnt     <= cnt_d;
            err_code    <= code_d;
            first_valid <= fv_d;
            first_stamp <= fs_d;
            armed       <= (state_d != ST_WARMUP);
            alarm       <= (state_d == ST_ALARM) || (state_d == ST_LATCHED);
            irq         <= (state_d == ST_ALARM);
        end
    end

    // Next-state, violation detection and counter/flag updates.
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        cyc_d    = cyc_q;
        cnt_d    = err_cnt;
        code_d   = err_code;
        fv_d     = first_valid;
        fs_d     = first_stamp;

        checking = (state_q != ST_WARMUP);
        v_cmp    = checking && (obs_o3 == obs_o2);
        v_shf    = checking && (obs_o2 != o1_prev_q);
        viol     = v_cmp || v_shf;

        if (clr) begin
            // Clear wins over any concurrent violation or acknowledge.
            state_d = ST_WARMUP;
            warm_d  = '0;
            cyc_d   = '0;
            cnt_d   = '0;
            code_d  = 2'b00;
            fv_d    = 1'b0;
            fs_d    = '0;
        end else begin
            if (checking) begin
                cyc_d = cyc_q + CYC_W'(1);
                if (viol) begin
                    if (err_cnt != CNT_MAX) begin
                        cnt_d = err_cnt + CNT_W'(1);
                    end
                    code_d = err_code | {v_shf, v_cmp};
                    if (!first_valid) begin
                        fv_d = 1'b1;
                        fs_d = cyc_q;
                    end
                end
            end

            case (state_q)
                ST_WARMUP: begin
                    // Masks the post-reset window where o2 = o3 = 0 upstream.
                    if (warm_q == WARM_LAST) begin
                        state_d = ST_ARMED;
                        warm_d  = '0;
                        cyc_d   = '0;
                    end else begin
                        warm_d = warm_q + WRM_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (cnt_d >= THRESH_V) begin
                        state_d = ST_ALARM;
                    end
                end
                ST_ALARM: begin
                    if (irq_ack) begin
                        state_d = ST_LATCHED;
                    end
                end
                default: begin
                    state_d = ST_LATCHED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fiapp_fault_monitor.sv
// Directed self-checking bench for fiapp_fault_monitor (WARMUP=2, THRESH=4,
// CNT_W=4 so that saturation at 15 is reachable quickly).
module tb_fiapp_fault_monitor;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned CYC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             obs_o1, obs_o2, obs_o3;
    logic             clr, irq_ack;
    logic             armed, alarm, irq;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       err_code;
    logic             first_valid;
    logic [CYC_W-1:0] first_stamp;

    int   checks = 0;
    int   errors = 0;
    logic prev   = 1'b0;

    fiapp_fault_monitor #(
        .WARMUP(2), .THRESH(4), .CNT_W(CNT_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .obs_o1(obs_o1), .obs_o2(obs_o2), .obs_o3(obs_o3),
        .clr(clr), .irq_ack(irq_ack),
        .armed(armed), .alarm(alarm), .irq(irq),
        .err_cnt(err_cnt), .err_code(err_code),
        .first_valid(first_valid), .first_stamp(first_stamp)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
    task automatic drive(input logic o1, input logic o2, input logic o3,
                         input logic ack, input logic c);
        obs_o1  = o1;
        obs_o2  = o2;
        obs_o3  = o3;
        irq_ack = ack;
        clr     = c;
        @(posedge clk);
        #1;
        prev = o1;
    endtask

    task automatic good(input logic ack);
        logic r;
        r = 1'($urandom_range(1, 0));
        drive(r, prev, !prev, ack, 1'b0);
    endtask

    task automatic bad_cmp(input logic ack, input logic c);
        logic r;
        r = 1'($urandom_range(1, 0));
        drive(r, prev, prev, ack, c);
    endtask

    task automatic bad_shf();
        logic r;
        r = 1'($urandom_range(1, 0));
        drive(r, !prev, prev, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        obs_o1 = 1'b0; obs_o2 = 1'b0; obs_o3 = 1'b0;
        clr = 1'b0; irq_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        prev  = 1'b0;
    endtask

    task automatic masking();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        obs_o1 = 1'b0; obs_o2 = 1'b0; obs_o3 = 1'b0;
        clr = 1'b0; irq_ack = 1'b0;
        #2;
        checks++;
        if ({armed, alarm, irq} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {armed, alarm, irq});
        end
        checks++;
        if (err_cnt !== '0 || err_code !== 2'b00) begin
            errors++; $display("FAIL reset_err got cnt=%0d code=%b exp 0/00", err_cnt, err_code);
        end
        checks++;
        if (first_valid !== 1'b0 || first_stamp !== '0) begin
            errors++; $display("FAIL reset_first got v=%b s=%0d exp 0/0", first_valid, first_stamp);
        end
        do_reset();
        // Post-reset masking: o2 = o3 = 0 would violate if checked.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b0) begin
            errors++; $display("FAIL warmup_edge1 armed got %b exp 0", armed);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b1) begin
            errors++; $display("FAIL warmup_edge2 armed got %b exp 1", armed);
        end
        checks++;
        if (err_cnt !== '0 || err_code !== 2'b00) begin
            errors++; $display("FAIL masking got cnt=%0d code=%b exp 0/00", err_cnt, err_code);
        end
    endtask

    task automatic test_fault_free();
        for (int i = 0; i < 200; i++) begin
            good(1'b0);
            checks++;
            if (err_cnt !== '0 || armed !== 1'b1) begin
                errors++;
                $display("FAIL fault_free cyc %0d got cnt=%0d armed=%b exp 0/1", i, err_cnt, armed);
            end
        end
        checks++;
        if (err_code !== 2'b00 || alarm !== 1'b0 || first_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_free_end got code=%b alarm=%b fv=%b exp 00/0/0", err_code, alarm, first_valid);
        end
    endtask

    task automatic test_complement();
        do_reset();
        masking();
        for (int i = 0; i < 10; i++) good(1'b0);
        for (int i = 0; i < 3; i++) bad_cmp(1'b0, 1'b0);
        checks++;
        if (err_cnt !== 4'd3 || irq !== 1'b0) begin
            errors++; $display("FAIL cmp_pre got cnt=%0d irq=%b exp 3/0", err_cnt, irq);
        end
        // Threshold reached with ack in the same cycle: ack is ignored.
        bad_cmp(1'b1, 1'b0);
        checks++;
        if (irq !== 1'b1 || alarm !== 1'b1 || err_cnt !== 4'd4) begin
            errors++; $display("FAIL cmp_alarm got irq=%b alarm=%b cnt=%0d exp 1/1/4", irq, alarm, err_cnt);
        end
        checks++;
        if (err_code !== 2'b01 || first_valid !== 1'b1 || first_stamp !== 16'd10) begin
            errors++;
            $display("FAIL cmp_record got code=%b fv=%b stamp=%0d exp 01/1/10", err_code, first_valid, first_stamp);
        end
        good(1'b1);
        checks++;
        if (irq !== 1'b0 || alarm !== 1'b1 || armed !== 1'b1) begin
            errors++; $display("FAIL cmp_ack got irq=%b alarm=%b armed=%b exp 0/1/1", irq, alarm, armed);
        end
        // LATCHED keeps counting; held ack has no further effect.
        bad_cmp(1'b1, 1'b0);
        checks++;
        if (err_cnt !== 4'd5 || irq !== 1'b0 || alarm !== 1'b1 || first_stamp !== 16'd10) begin
            errors++;
            $display("FAIL latched got cnt=%0d irq=%b alarm=%b stamp=%0d exp 5/0/1/10", err_cnt, irq, alarm, first_stamp);
        end
    endtask

    task automatic test_shift();
        do_reset();
        masking();
        // Ack outside ALARM is ignored.
        for (int i = 0; i < 5; i++) good(1'b1);
        bad_shf();
        checks++;
        if (err_code !== 2'b10 || err_cnt !== 4'd1) begin
            errors++; $display("FAIL shift got code=%b cnt=%0d exp 10/1", err_code, err_cnt);
        end
        checks++;
        if (first_stamp !== 16'd5 || armed !== 1'b1 || alarm !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL shift_state got stamp=%0d armed=%b alarm=%b irq=%b exp 5/1/0/0", first_stamp, armed, alarm, irq);
        end
        good(1'b0);
        checks++;
        if (err_cnt !== 4'd1 || alarm !== 1'b0) begin
            errors++; $display("FAIL shift_after got cnt=%0d alarm=%b exp 1/0", err_cnt, alarm);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        masking();
        for (int i = 0; i < 20; i++) bad_cmp(1'b0, 1'b0);
        checks++;
        if (err_cnt !== 4'd15 || irq !== 1'b1) begin
            errors++; $display("FAIL saturate got cnt=%0d irq=%b exp 15/1", err_cnt, irq);
        end
        // Clear together with a violation: clear wins.
        bad_cmp(1'b0, 1'b1);
        checks++;
        if (err_cnt !== '0 || err_code !== 2'b00 || first_valid !== 1'b0 || first_stamp !== '0) begin
            errors++;
            $display("FAIL clr_fields got cnt=%0d code=%b fv=%b stamp=%0d exp 0/00/0/0", err_cnt, err_code, first_valid, first_stamp);
        end
        checks++;
        if ({armed, alarm, irq} !== 3'b000) begin
            errors++; $display("FAIL clr_flags got %b exp 000", {armed, alarm, irq});
        end
        good(1'b0);
        checks++;
        if (armed !== 1'b0) begin
            errors++; $display("FAIL clr_warm1 armed got %b exp 0", armed);
        end
        good(1'b0);
        checks++;
        if (armed !== 1'b1 || err_cnt !== '0) begin
            errors++; $display("FAIL clr_warm2 got armed=%b cnt=%0d exp 1/0", armed, err_cnt);
        end
    endtask

    task automatic test_reset_mid_alarm();
        for (int i = 0; i < 4; i++) bad_cmp(1'b0, 1'b0);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL pre_reset irq got %b exp 1", irq);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({armed, alarm, irq} !== 3'b000 || err_cnt !== '0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL async_reset got flags=%b cnt=%0d code=%b exp 000/0/00", {armed, alarm, irq}, err_cnt, err_code);
        end
        checks++;
        if (first_valid !== 1'b0 || first_stamp !== '0) begin
            errors++; $display("FAIL async_reset_first got v=%b s=%0d exp 0/0", first_valid, first_stamp);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        prev  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_complement();
        test_shift();
        test_saturation();
        test_reset_mid_alarm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
